// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the pd data-memory responder.
//   mem_size_e  : request access size (byte / half / word / illegal)
//   dmem_rsp_t  : one response as it travels the latency pipeline and buffer
//   RSP_DEPTH   : response credits; bounds pipeline + buffer occupancy
//   lane_mask   : byte-lane enables for a store of a given size and offset
//   load_extend : right-align a loaded byte/half and sign- or zero-extend it
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

  localparam int RSP_DEPTH = 2;

  function automatic logic [3:0] lane_mask(input mem_size_e size, input logic [1:0] off);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << off;
      SZ_H:    lane_mask = 4'b0011 << off;
      SZ_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_size_e size,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    load_extend = uns ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_extend = uns ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// dmem_rsp_fifo: 2-entry response buffer; slot0 is always the head.
//   clk, rst_n             : clock, asynchronous active-low reset
//   push_valid, push_data  : new response (caller guarantees no overflow)
//   pop_ready              : consumer takes the head this cycle
//   pop_valid, pop_data    : head of buffer
//   count                  : entries held (0..2)
module dmem_rsp_fifo
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_valid,
  input  dmem_rsp_t  push_data,
  input  logic       pop_ready,
  output logic       pop_valid,
  output dmem_rsp_t  pop_data,
  output logic [1:0] count
);

  dmem_rsp_t slot0, slot1;
  logic      pop;

  assign pop_valid = (count != 2'd0);
  assign pop       = pop_valid && pop_ready;
  assign pop_data  = slot0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push_valid, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Head leaves as the new entry arrives; count is unchanged.
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store slave for the pd pipeline's memory stage.
// Requests are accepted on req_valid && req_ready; stores commit and loads
// sample the word array at the accept edge; results flow through a
// (LATENCY-1)-stage pipeline into a 2-entry response buffer.
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_addr, req_we, req_wdata, req_size, req_unsigned
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                AWIDTH      = 32,
  parameter int                DWIDTH      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 2,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic              req_we,
  input  logic [DWIDTH-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [AWIDTH-1:0] SPAN    = AWIDTH'(DEPTH_WORDS * 4);
  localparam logic [2:0]        CREDITS = 3'(RSP_DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH_WORDS];

  mem_size_e         size;
  logic [AWIDTH-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              bad;
  logic              accept;
  logic              pop;
  logic [3:0]        mask;
  logic [31:0]       wdata_sh;
  dmem_rsp_t         acc_rsp;
  logic              ready_en;
  logic              push_valid;
  dmem_rsp_t         push_data;
  logic [1:0]        pipe_cnt;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  dmem_rsp_t         head;

  assign size = mem_size_e'(req_size);
  // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
  assign off  = req_addr - BASE_ADDR;
  assign idx  = off[IDX_W+1:2];
  assign lane = req_addr[1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    bad = 1'b0;
    case (size)
      SZ_H:    bad = req_addr[0];
      SZ_W:    bad = (lane != 2'b00);
      SZ_BAD:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    if (off >= SPAN) bad = 1'b1;
  end

  assign acc_rsp.err   = bad;
  assign acc_rsp.rdata = (bad || req_we) ? 32'h0
                                         : load_extend(mem[idx], size, lane, req_unsigned);

  assign mask     = lane_mask(size, lane);
  assign wdata_sh = req_wdata << {lane, 3'b000};

  // NOTE: the storage array has no reset; clearing a RAM costs a full sweep and
  // software never relies on its initial contents. Stores only commit on an
  // accept, and req_ready is low throughout reset, so nothing partial lands.
  always_ff @(posedge clk) begin
    if (accept && req_we && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  if (LATENCY == 1) begin : g_direct
    assign push_valid = accept;
    assign push_data  = acc_rsp;
    assign pipe_cnt   = 2'd0;
  end else begin : g_pipe
    localparam int N = LATENCY - 1;
    logic [N-1:0] pv;
    dmem_rsp_t    pd [N];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pv <= '0;
      end else begin
        pv[0] <= accept;
        for (int i = 1; i < N; i++) pv[i] <= pv[i-1];
      end
    end

    // Payload follows its valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
      pd[0] <= acc_rsp;
      for (int i = 1; i < N; i++) pd[i] <= pd[i-1];
    end

    assign push_valid = pv[N-1];
    assign push_data  = pd[N-1];
    // Credit rule caps in-flight requests at 2, so two bits suffice.
    assign pipe_cnt   = 2'($countones(pv));
  end

  dmem_rsp_fifo u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_valid (push_valid),
    .push_data  (push_data),
    .pop_ready  (rsp_ready),
    .pop_valid  (rsp_valid),
    .pop_data   (head),
    .count      (fifo_cnt)
  );

  assign pop = rsp_valid && rsp_ready;
  assign occ = 3'(pipe_cnt) + 3'(fifo_cnt);

  // A full buffer may still take a request when its head leaves this cycle.
  assign req_ready = ready_en && ((occ < CREDITS) || ((occ == CREDITS) && pop));
  assign accept    = req_valid && req_ready;

  assign rsp_rdata = rsp_valid ? head.rdata : '0;
  assign rsp_err   = rsp_valid && head.err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder. The driver pushes the
// expected response of each accepted request; an independent monitor pops and
// compares whenever a response is handed over. Expected values come from a
// byte-addressed reference memory.
module tb_dmem_responder;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(
    .AWIDTH(32), .DWIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    bit          exact;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mb [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: memory is a flat byte map; loads assemble bytes arithmetically.
  function automatic void model(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns,
                                output logic [31:0] rdata, output logic err);
    int     n;
    longint off;
    longint val;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = longint'(addr) - longint'(BASE);
    err = (size == 2'd3) || ((addr % n) != 0) || (off < 0) || (off >= 4 * DEPTH);
    rdata = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) mb[int'(off) + i] = wdata[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < n; i++) val = val | (longint'(mb[int'(off) + i]) << (8 * i));
      if (!uns && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
      rdata = val[31:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) rsp_ready = ($urandom_range(0, 99) < 70);
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       input bit use_exp = 1'b0, input logic [31:0] exp_rdata = '0,
                       input logic exp_err = 1'b0);
    exp_t e;
    req_addr = addr; req_we = we; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (req_ready) begin
        model(addr, we, wdata, size, uns, e.rdata, e.err);
        if (use_exp) begin
          e.rdata = exp_rdata;
          e.err   = exp_err;
        end
        e.acc_cyc = cyc;
        e.exact   = (sb.size() == 0);
        sb.push_back(e);
        tick();
        req_valid = 1'b0;
        return;
      end
      if (n == 60) begin
        check("accept_timeout", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        return;
      end
      tick();
    end
  endtask

  task automatic ld(input int ofs, input logic [1:0] size, input logic uns, input logic [31:0] exp);
    issue(BASE + 32'(ofs), 1'b0, '0, size, uns, 1'b1, exp, 1'b0);
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && sb.size() != 0; n++) tick();
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: samples between edges, after the driver's accept bookkeeping.
  initial begin
    bit          head_seen = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic        prev_err = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        head_seen  = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", {31'b0, rsp_valid}, 32'd1);
          check("stall_rdata", rsp_rdata, prev_rdata);
          check("stall_err", {31'b0, rsp_err}, {31'b0, prev_err});
        end
        if (sb.size() == 0) begin
          check("underflow_valid", {31'b0, rsp_valid}, 32'd0);
        end else if (rsp_valid) begin
          e = sb[0];
          if (!head_seen) begin
            head_seen = 1'b1;
            if (e.exact) check("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
            else         check("latency_min", {31'b0, (cyc - e.acc_cyc) >= LAT}, 32'd1);
          end
          if (rsp_ready) begin
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
        check("occupancy_le_2", {31'b0, sb.size() <= 2}, 32'd1);
        stall_prev = rsp_valid && !rsp_ready;
        prev_rdata = rsp_rdata;
        prev_err   = rsp_err;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish, expected finish within 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;

    // Reset values while reset is held.
    #12;
    check("reset_req_ready", {31'b0, req_ready}, 32'd0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_before_edge", {31'b0, req_ready}, 32'd0);
    tick();
    check("ready_after_edge", {31'b0, req_ready}, 32'd1);

    // Known contents in a 16-word window.
    for (int i = 0; i < 16; i++) issue(BASE + 32'(4 * i), 1'b1, 32'h1000_0000 + 32'(i) * 32'h0101_0101, 2'd2, 1'b0);
    repeat (4) tick();

    // Word store/load and extension.
    issue(BASE + 32'd4, 1'b1, 32'hDEAD_BEEF, 2'd2, 1'b0);
    repeat (4) tick();
    ld(4, 2'd2, 1'b0, 32'hDEAD_BEEF);
    ld(7, 2'd0, 1'b0, 32'hFFFF_FFDE);
    ld(7, 2'd0, 1'b1, 32'h0000_00DE);
    ld(4, 2'd1, 1'b0, 32'hFFFF_BEEF);
    ld(6, 2'd1, 1'b1, 32'h0000_DEAD);

    // Byte store followed back-to-back by a word load.
    issue(BASE + 32'd5, 1'b1, 32'h0000_0055, 2'd0, 1'b0);
    ld(4, 2'd2, 1'b0, 32'hDEAD_55EF);

    // Errors leave memory untouched.
    issue(BASE + 32'd3, 1'b0, '0, 2'd1, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(BASE + 32'd2, 1'b1, 32'hFFFF_FFFF, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(BASE + 32'd4096, 1'b0, '0, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(BASE - 32'd4, 1'b0, '0, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(BASE + 32'd8, 1'b0, '0, 2'd3, 1'b0, 1'b1, 32'h0, 1'b1);
    ld(0, 2'd2, 1'b0, 32'h1000_0000);

    // Last word of the array is in range.
    issue(BASE + 32'd4092, 1'b1, 32'hCAFE_F00D, 2'd2, 1'b0);
    ld(4092, 2'd2, 1'b0, 32'hCAFE_F00D);
    drain(40);

    // Backpressure: two accepted, the third held off until a pop.
    rsp_ready = 1'b0;
    ld(8, 2'd2, 1'b0, 32'h1202_0202);
    ld(12, 2'd2, 1'b0, 32'h1303_0303);
    req_addr = BASE + 32'd16; req_we = 1'b0; req_size = 2'd2; req_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    ld(16, 2'd2, 1'b0, 32'h1404_0404);
    ld(20, 2'd2, 1'b0, 32'h1505_0505);
    drain(40);

    // Reset with two responses pending.
    rsp_ready = 1'b0;
    ld(24, 2'd2, 1'b0, 32'h1606_0606);
    ld(28, 2'd2, 1'b0, 32'h1707_0707);
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midreset_req_ready", {31'b0, req_ready}, 32'd0);
    sb.delete();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("release_ready_low", {31'b0, req_ready}, 32'd0);
    tick();
    check("release_ready_high", {31'b0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    repeat (6) tick();
    ld(4, 2'd2, 1'b0, 32'hDEAD_55EF);
    drain(40);

    // Randomized traffic against the reference memory.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'd4096 + 32'($urandom_range(0, 63));
        1:       a = BASE - 32'd1 - 32'($urandom_range(0, 63));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && $urandom_range(0, 1) == 1) sz = 2'd2;
      issue(a, 1'($urandom_range(0, 1)), $urandom, sz, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rand_ready = 1'b0;
    rsp_ready  = 1'b1;
    drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
